fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 184 ++++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a first-word-fall-through FIFO and sends each one
//   as an 8N1-style UART frame (start, dataBits LSB first, optional parity, stop).
// Latency: the pop happens in the same cycle that fifoNE is seen in IDLE, and tx
//   goes low on the next edge. Consecutive frames run back-to-back with no idle gap.
// Backpressure: the FIFO is popped only when a new frame can begin. fifoNE and
//   fifoData are ignored for the rest of the frame.
//
// Build option: define FIFO_UART_TX_PARITY_EN to add an even-parity bit between
//   the last data bit and the stop bit.
//
// Ports:
//   clk      - clock; all state updates happen on its rising edge
//   reset    - asynchronous active-high reset; it aborts any frame in progress
//   fifoNE   - FIFO not-empty; fifoData is valid while this is high
//   fifoData - word at the head of the FIFO
//   fifoRdEn - one-cycle pop strobe, asserted once per frame
//   tx       - registered serial output; high when idle
//   busy     - high whenever a frame is in progress
//   txDone   - one-cycle pulse on the last cycle of each stop bit
module fifo_uart_tx #(
  parameter int dataBits   = 8,
  parameter int clksPerBit = 868
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fifoNE,
  input  logic [dataBits-1:0] fifoData,
  output logic                fifoRdEn,
  output logic                tx,
  output logic                busy,
  output logic                txDone
);

  localparam int CW = (clksPerBit > 1) ? $clog2(clksPerBit) : 1;
  localparam int IW = (dataBits > 1) ? $clog2(dataBits) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(clksPerBit - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(dataBits - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_idx;
  logic [dataBits-1:0] r_shreg;
  logic                r_tx;

  state_t              w_state_nxt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [IW-1:0]       w_idx_nxt;
  logic [dataBits-1:0] w_shreg_nxt;
  logic [dataBits-1:0] w_shifted;
  logic                w_tx_nxt;
  logic                w_bit_end;
  logic                w_load;

`ifdef FIFO_UART_TX_PARITY_EN
  // The shift register is consumed as the data bits go out, so the parity of the
  // word is captured when the word is loaded.
  logic r_parity;
`endif

  always_comb begin
    w_bit_end   = (r_cnt == LAST_CNT);
    w_shifted   = r_shreg >> 1;
    w_state_nxt = r_state;
    w_cnt_nxt   = w_bit_end ? '0 : r_cnt + CW'(1);
    w_idx_nxt   = r_idx;
    w_shreg_nxt = r_shreg;
    w_tx_nxt    = r_tx;
    w_load      = 1'b0;

    // w_tx_nxt is the line level for the next cycle. Because tx is registered
    // from it, tx only changes on the edge that starts a new bit.
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        w_tx_nxt  = 1'b1;
        if (fifoNE) begin
          w_load      = 1'b1;
          w_state_nxt = START;
          w_tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt = DATA;
          w_idx_nxt   = '0;
          w_tx_nxt    = r_shreg[0];
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_idx == LAST_IDX) begin
`ifdef FIFO_UART_TX_PARITY_EN
            w_state_nxt = PARITY;
            w_tx_nxt    = r_parity;
`else
            w_state_nxt = STOP;
            w_tx_nxt    = 1'b1;
`endif
          end else begin
            w_idx_nxt   = r_idx + IW'(1);
            w_shreg_nxt = w_shifted;
            w_tx_nxt    = w_shifted[0];
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = STOP;
          w_tx_nxt    = 1'b1;
        end
      end
`endif
      STOP: begin
        // On the final stop cycle, chain straight into the next frame if a
        // word is already waiting.
        if (w_bit_end) begin
          if (fifoNE) begin
            w_load      = 1'b1;
            w_state_nxt = START;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = IDLE;
            w_tx_nxt    = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase

    if (w_load) begin
      w_shreg_nxt = fifoData;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shreg <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shreg <= w_shreg_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

`ifdef FIFO_UART_TX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if (w_load) begin
      r_parity <= ^fifoData;
    end
  end
`endif

  // The pop is gated by reset so that a word can never be lost while the
  // block is held in reset.
  assign fifoRdEn = w_load & ~reset;
  assign tx       = r_tx;
  assign busy     = (r_state != IDLE);
  assign txDone   = (r_state == STOP) & w_bit_end;

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

  localparam int DB  = 8;
  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int FRAME_BITS = DB + 3;
`else
  localparam int FRAME_BITS = DB + 2;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fifoNE = 1'b0;
  logic [DB-1:0] fifoData = '0;
  logic          fifoRdEn, tx, busy, txDone;

  fifo_uart_tx #(.dataBits(DB), .clksPerBit(CPB)) dut (
    .clk(clk), .reset(reset), .fifoNE(fifoNE), .fifoData(fifoData),
    .fifoRdEn(fifoRdEn), .tx(tx), .busy(busy), .txDone(txDone)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: the FIFO is a queue of words, and the line is described as
  // a list of frame bits. Each bit lasts CPB cycles, and frames chain with no gap.
  logic [DB-1:0] q[$];
  bit            m_active = 0;
  int            m_pos = 0;
  bit            m_bits[0:15];
  int            n_busy = 0, n_pop = 0, n_done = 0;

  function automatic void load_frame(input logic [DB-1:0] w);
    m_bits[0] = 1'b0;
    for (int i = 0; i < DB; i++) m_bits[1+i] = w[i];
`ifdef FIFO_UART_TX_PARITY_EN
    m_bits[DB+1] = ^w;
`endif
    m_bits[FRAME_BITS-1] = 1'b1;
    m_active = 1;
    m_pos    = 0;
  endfunction

  task automatic drive_fifo();
    fifoNE   = (q.size() != 0);
    fifoData = fifoNE ? q[0] : DB'($urandom);
  endtask

  task automatic step();
    bit e_tx, e_busy, e_done, e_rd, pop;
    @(negedge clk);
    pop = 0;
    if (reset) begin
      e_tx = 1; e_busy = 0; e_done = 0; e_rd = 0;
      m_active = 0; m_pos = 0;
    end else if (!m_active) begin
      e_tx = 1; e_busy = 0; e_done = 0;
      e_rd = (q.size() != 0);
      if (e_rd) begin load_frame(q[0]); pop = 1; end
    end else begin
      e_tx   = m_bits[m_pos / CPB];
      e_busy = 1;
      e_done = (m_pos == FRAME_BITS * CPB - 1);
      e_rd   = e_done && (q.size() != 0);
      if (e_rd) begin load_frame(q[0]); pop = 1; end
      else if (e_done) m_active = 0;
      else m_pos++;
    end
    check("tx", 32'(tx), 32'(e_tx));
    check("busy", 32'(busy), 32'(e_busy));
    check("txDone", 32'(txDone), 32'(e_done));
    check("fifoRdEn", 32'(fifoRdEn), 32'(e_rd));
    if (busy) n_busy++;
    if (fifoRdEn) n_pop++;
    if (txDone) n_done++;
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    drive_fifo();
  endtask

  task automatic run_until_idle(input int budget);
    int c = 0;
    while ((m_active || q.size() != 0) && c < budget) begin
      step();
      c++;
    end
    check("drain", 32'(m_active || q.size() != 0), 32'd0);
  endtask

  task automatic clear_stats();
    n_busy = 0; n_pop = 0; n_done = 0;
  endtask

  initial begin
    // Reset state.
    repeat (3) step();
    reset = 0;

    // Empty FIFO: the line stays idle.
    clear_stats();
    repeat (100) step();
    check("idle_busy_cnt", 32'(n_busy), 32'd0);
    check("idle_pop_cnt", 32'(n_pop), 32'd0);

    // A single 0xA5 frame.
    clear_stats();
    q.push_back(8'hA5); drive_fifo();
    run_until_idle(200);
    step();
    check("a5_busy_cycles", 32'(n_busy), 32'(FRAME_BITS * CPB));
    check("a5_pops", 32'(n_pop), 32'd1);
    check("a5_done", 32'(n_done), 32'd1);

    // 0x00 followed by 0xFF, sent back to back.
    clear_stats();
    q.push_back(8'h00); q.push_back(8'hFF); drive_fifo();
    run_until_idle(300);
    check("b2b_busy_cycles", 32'(n_busy), 32'(2 * FRAME_BITS * CPB));
    check("b2b_pops", 32'(n_pop), 32'd2);
    check("b2b_done", 32'(n_done), 32'd2);

`ifdef FIFO_UART_TX_PARITY_EN
    // Parity frames.
    clear_stats();
    q.push_back(8'h07); drive_fifo();
    run_until_idle(200);
    check("p07_busy_cycles", 32'(n_busy), 32'd44);
    clear_stats();
    q.push_back(8'hA5); drive_fifo();
    run_until_idle(200);
    check("pa5_busy_cycles", 32'(n_busy), 32'd44);
`endif

    // Random words pushed at random times.
    clear_stats();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0 && q.size() < 3) begin
        q.push_back(DB'($urandom));
        drive_fifo();
      end
      step();
    end
    run_until_idle(2000);

    // Reset asserted during data bit 3 of 0x3C.
    clear_stats();
    q.push_back(8'h3C); drive_fifo();
    begin
      int c = 0;
      while (!(m_active && m_pos == 4 * CPB + 1) && c < 100) begin
        step();
        c++;
      end
      check("reach_bit3", 32'(m_active && m_pos == 4 * CPB + 1), 32'd1);
    end
    #1 reset = 1;
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(txDone), 32'd0);
    check("rst_rd", 32'(fifoRdEn), 32'd0);
    m_active = 0;
    repeat (3) step();
    reset = 0;
    clear_stats();
    repeat (30) step();
    check("post_rst_pops", 32'(n_pop), 32'd0);

    // A word that is queued during reset is popped on the first cycle after release.
    reset = 1;
    q.push_back(8'h5A); drive_fifo();
    repeat (3) step();
    reset = 0;
    clear_stats();
    run_until_idle(200);
    check("after_rst_pops", 32'(n_pop), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1);
  end

endmodule
